// File: rtl/eship_formation_if.sv
// ---------------------------------------------------------------------------
// eship_formation_if
// Bundle of the signals that run between the fleet formation controller,
// the four eship_row instances and the top-level game FSM.
//   slave  : the formation controller (takes frame/game/row status,
//            drives row offsets and wave status)
//   master : the environment that drives the controller
// Signals:
//   frame_clk            ~60 Hz frame strobe (asynchronous to Clk)
//   play                 game in play; low pauses the march
//   done                 synchronous restart of the formation
//   score_row0..3        ships destroyed per row (0..6)
//   laser_hit_row0..3    per-row laser hit level
//   gameover_row0..3     per-row "ship reached the player"
//   y_offset0..3         per-row vertical offset
//   total_score          registered sum of the row scores
//   wave_cleared         high in CLEARED
//   enemies_won          high in LOST
//   fstate               IDLE=0, MARCH=1, CLEARED=2, LOST=3
// ---------------------------------------------------------------------------
interface eship_formation_if;
    logic       frame_clk;
    logic       play;
    logic       done;
    logic [4:0] score_row0;
    logic [4:0] score_row1;
    logic [4:0] score_row2;
    logic [4:0] score_row3;
    logic       laser_hit_row0;
    logic       laser_hit_row1;
    logic       laser_hit_row2;
    logic       laser_hit_row3;
    logic       gameover_row0;
    logic       gameover_row1;
    logic       gameover_row2;
    logic       gameover_row3;
    logic [9:0] y_offset0;
    logic [9:0] y_offset1;
    logic [9:0] y_offset2;
    logic [9:0] y_offset3;
    logic [7:0] total_score;
    logic       wave_cleared;
    logic       enemies_won;
    logic [1:0] fstate;

    modport slave (
        input  frame_clk, play, done,
        input  score_row0, score_row1, score_row2, score_row3,
        input  laser_hit_row0, laser_hit_row1, laser_hit_row2, laser_hit_row3,
        input  gameover_row0, gameover_row1, gameover_row2, gameover_row3,
        output y_offset0, y_offset1, y_offset2, y_offset3,
        output total_score, wave_cleared, enemies_won, fstate
    );

    modport master (
        output frame_clk, play, done,
        output score_row0, score_row1, score_row2, score_row3,
        output laser_hit_row0, laser_hit_row1, laser_hit_row2, laser_hit_row3,
        output gameover_row0, gameover_row1, gameover_row2, gameover_row3,
        input  y_offset0, y_offset1, y_offset2, y_offset3,
        input  total_score, wave_cleared, enemies_won, fstate
    );
endinterface

// File: rtl/eship_formation.sv
// ---------------------------------------------------------------------------
// eship_formation
// Enemy fleet formation controller. Paces the fleet's descent from the frame
// strobe, speeds the march up on every laser hit, tallies the wave score and
// declares the wave cleared or lost.
// Ports:
//   Clk    : system clock (the only clock)
//   Reset  : asynchronous, active-low reset
//   fif    : eship_formation_if.slave (frame strobe, game control, row
//            status in; row offsets, score and wave status out)
// ---------------------------------------------------------------------------
module eship_formation #(
    parameter int START_Y     = 40,
    parameter int ROW_SPACING = 40,
    parameter int STEP_PX     = 8,
    parameter int STEP_FRAMES = 30,
    parameter int MIN_FRAMES  = 6,
    parameter int FLOOR_Y     = 400,
    parameter int SHIPS_TOTAL = 24
) (
    input  logic               Clk,
    input  logic               Reset,
    eship_formation_if.slave   fif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MARCH   = 2'd1,
        S_CLEARED = 2'd2,
        S_LOST    = 2'd3
    } fstate_t;

    localparam logic [9:0]  START_Y_C     = 10'(START_Y);
    localparam logic [9:0]  STEP_PX_C     = 10'(STEP_PX);
    localparam logic [5:0]  STEP_FRAMES_C = 6'(STEP_FRAMES);
    localparam logic [5:0]  MIN_FRAMES_C  = 6'(MIN_FRAMES);
    localparam logic [10:0] BOTTOM_OFS_C  = 11'(3 * ROW_SPACING);
    localparam logic [10:0] FLOOR_Y_C     = 11'(FLOOR_Y);
    localparam logic [7:0]  SHIPS_TOTAL_C = 8'(SHIPS_TOTAL);
    localparam logic [9:0]  SPACING_C     = 10'(ROW_SPACING);

    fstate_t    state_q, state_d;
    logic [9:0] base_y_q, base_y_d;
    logic [5:0] frame_cnt_q, frame_cnt_d;
    logic [5:0] step_frames_q, step_frames_d;
    logic [7:0] total_score_q, total_score_d;

    // frame strobe synchronizer, edge history and registered tick
    logic fs1_q, fs2_q, fs3_q, tick_q, tick_d;
    // laser hit OR, edge history and registered hit pulse
    logic lh_q, lh_prev_q, hit_q, hit_d;

    logic [10:0] bottom_y;
    logic        lost_cond;
    logic        clear_cond;

    always_comb begin
        tick_d = fs2_q & ~fs3_q;
        hit_d  = lh_q & ~lh_prev_q;
    end

    // 11 bits so the bottom-row comparison cannot wrap
    assign bottom_y   = {1'b0, base_y_q} + BOTTOM_OFS_C;
    assign lost_cond  = fif.gameover_row0 | fif.gameover_row1 |
                        fif.gameover_row2 | fif.gameover_row3 |
                        (bottom_y >= FLOOR_Y_C);
    assign clear_cond = (total_score_q >= SHIPS_TOTAL_C);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            fs1_q         <= 1'b0;
            fs2_q         <= 1'b0;
            fs3_q         <= 1'b0;
            tick_q        <= 1'b0;
            lh_q          <= 1'b0;
            lh_prev_q     <= 1'b0;
            hit_q         <= 1'b0;
            state_q       <= S_IDLE;
            base_y_q      <= START_Y_C;
            frame_cnt_q   <= 6'd0;
            step_frames_q <= STEP_FRAMES_C;
            total_score_q <= 8'd0;
        end else begin
            fs1_q         <= fif.frame_clk;
            fs2_q         <= fs1_q;
            fs3_q         <= fs2_q;
            tick_q        <= tick_d;
            lh_q          <= fif.laser_hit_row0 | fif.laser_hit_row1 |
                             fif.laser_hit_row2 | fif.laser_hit_row3;
            lh_prev_q     <= lh_q;
            hit_q         <= hit_d;
            state_q       <= state_d;
            base_y_q      <= base_y_d;
            frame_cnt_q   <= frame_cnt_d;
            step_frames_q <= step_frames_d;
            total_score_q <= total_score_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        base_y_d      = base_y_q;
        frame_cnt_d   = frame_cnt_q;
        step_frames_d = step_frames_q;
        total_score_d = 8'(fif.score_row0) + 8'(fif.score_row1) +
                        8'(fif.score_row2) + 8'(fif.score_row3);

        if (fif.done) begin
            state_d       = S_IDLE;
            base_y_d      = START_Y_C;
            frame_cnt_d   = 6'd0;
            step_frames_d = STEP_FRAMES_C;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fif.play) state_d = S_MARCH;
                end
                S_MARCH: begin
                    // play low freezes everything, exits included
                    if (fif.play) begin
                        if (lost_cond) begin
                            state_d = S_LOST;
                        end else if (clear_cond) begin
                            state_d = S_CLEARED;
                        end else begin
                            // >= rather than == so a hit that shrinks
                            // step_frames below frame_cnt still steps
                            if (tick_q) begin
                                if (frame_cnt_q >= step_frames_q - 6'd1) begin
                                    frame_cnt_d = 6'd0;
                                    base_y_d    = base_y_q + STEP_PX_C;
                                end else begin
                                    frame_cnt_d = frame_cnt_q + 6'd1;
                                end
                            end
                            if (hit_q) begin
                                if (step_frames_q >= MIN_FRAMES_C + 6'd2)
                                    step_frames_d = step_frames_q - 6'd2;
                                else
                                    step_frames_d = MIN_FRAMES_C;
                            end
                        end
                    end
                end
                default: ;  // CLEARED / LOST hold until done or reset
            endcase
        end
    end

    assign fif.y_offset0    = base_y_q;
    assign fif.y_offset1    = base_y_q + SPACING_C;
    assign fif.y_offset2    = base_y_q + (SPACING_C << 1);
    assign fif.y_offset3    = base_y_q + 10'(3 * ROW_SPACING);
    assign fif.total_score  = total_score_q;
    assign fif.wave_cleared = (state_q == S_CLEARED);
    assign fif.enemies_won  = (state_q == S_LOST);
    assign fif.fstate       = state_q;

endmodule
